// File: rtl/johnson_pkg.sv
// Shared types and constants for the Johnson-code receive checker.
// FSM state encoding, lock counter width and error counter ceiling.
package johnson_pkg;

  typedef enum logic [1:0] {
    HUNT,
    ACQUIRE,
    LOCKED
  } state_t;

  localparam int LCW = 4;
  localparam int ERR_MAX = 255;
  localparam logic [7:0] ERR_MAX_V = 8'(ERR_MAX);

  // A clear in the same cycle as an error leaves exactly that error counted.
  function automatic logic [7:0] err_next(
    input logic [7:0] cur,
    input logic       ev,
    input logic       clr
  );
    if (clr)
      return {7'b0, ev};
    if (ev && cur != ERR_MAX_V)
      return cur + 8'd1;
    return cur;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson decoder: legality by bit-transition count,
// position from popcount and the LSB.
module johnson_decode #(
  parameter int WIDTH = 8,
  parameter int PW    = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [PW-1:0]    pos
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] ones;
  logic [CW-1:0] edges;

  always_comb begin
    ones  = '0;
    edges = '0;
    for (int i = 0; i < WIDTH; i++)
      ones = ones + CW'(code[i]);
    for (int i = 0; i < WIDTH - 1; i++)
      edges = edges + CW'(code[i] ^ code[i+1]);
    legal = (edges <= CW'(1));
    if (code[0])
      pos = PW'(ones);
    else if (ones == '0)
      pos = '0;
    else
      pos = PW'(2 * WIDTH - int'(ones));
  end

endmodule

// File: rtl/johnson_rx_checker.sv
// Two-stage Johnson sample checker: register, decode, track
// step continuity with a HUNT/ACQUIRE/LOCKED FSM and count errors.
module johnson_rx_checker
  import johnson_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOCK_STEPS = 4,
  parameter int PW         = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] code_in,
  input  logic             code_vld,
  input  logic             clr_err,
  output logic [PW-1:0]    pos,
  output logic             pos_vld,
  output logic             dir,
  output logic             locked,
  output logic             illegal,
  output logic             seq_err,
  output logic [7:0]       err_count
);

  localparam int M = 2 * WIDTH;
  localparam logic [PW-1:0] TOP = PW'(M - 1);
  localparam logic [LCW-1:0] LOCK_N = LCW'(LOCK_STEPS);

  logic [WIDTH-1:0] s1_code;
  logic             s1_vld;

  logic             d_legal;
  logic [PW-1:0]    d_pos;

  state_t           state;
  logic [LCW-1:0]   step_cnt;

  logic [PW-1:0]    ref_up;
  logic [PW-1:0]    ref_dn;
  logic             is_hold;
  logic             is_step;
  logic             is_jump;
  logic             err_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_code <= '0;
    end else begin
      s1_vld  <= code_vld;
      s1_code <= code_in;
    end
  end

  johnson_decode #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_dec (
    .code  (s1_code),
    .legal (d_legal),
    .pos   (d_pos)
  );

  // pos always holds the last legal sample, so it is the reference.
  always_comb begin
    ref_up  = (pos == TOP) ? '0 : pos + PW'(1);
    ref_dn  = (pos == '0) ? TOP : pos - PW'(1);
    is_hold = (d_pos == pos);
    is_step = (d_pos == ref_up) || (d_pos == ref_dn);
    is_jump = !is_hold && !is_step;
    err_ev  = s1_vld &&
              (!d_legal || (is_jump && state != HUNT));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      step_cnt  <= '0;
      pos       <= '0;
      pos_vld   <= 1'b0;
      dir       <= 1'b0;
      locked    <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= '0;
    end else begin
      pos_vld   <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      err_count <= err_next(err_count, err_ev, clr_err);
      if (s1_vld) begin
        if (!d_legal) begin
          illegal <= 1'b1;
          state   <= HUNT;
          locked  <= 1'b0;
        end else begin
          pos_vld <= 1'b1;
          pos     <= d_pos;
          unique case (state)
            HUNT: begin
              state    <= ACQUIRE;
              step_cnt <= '0;
            end
            ACQUIRE: begin
              if (is_step) begin
                dir      <= (d_pos == ref_up);
                step_cnt <= step_cnt + LCW'(1);
                if (step_cnt + LCW'(1) == LOCK_N) begin
                  state  <= LOCKED;
                  locked <= 1'b1;
                end
              end else if (is_jump) begin
                seq_err  <= 1'b1;
                step_cnt <= '0;
              end
            end
            LOCKED: begin
              if (is_step) begin
                dir <= (d_pos == ref_up);
              end else if (is_jump) begin
                seq_err  <= 1'b1;
                state    <= ACQUIRE;
                locked   <= 1'b0;
                step_cnt <= '0;
              end
            end
            default: begin
              state  <= HUNT;
              locked <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/johnson_rx_checker.md
JOHNSON_RX_CHECKER -- requirements
Module: johnson_rx_checker

Interface
REQ-001 Parameter WIDTH, default 8, Johnson code width N (legal 2..16); code has 2N states.
REQ-002 Parameter LOCK_STEPS, default 4, consecutive good steps needed to lock (1..15).
REQ-003 Parameter PW, default $clog2(2*WIDTH), position width (4 for WIDTH=8).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 code_in  input  WIDTH  Johnson code sampled from remote counter.
REQ-007 code_vld  input  1  code_in qualifier; sampled only when high.
REQ-008 clr_err  input  1  synchronous clear of err_count.
REQ-009 pos  output  PW  decoded position 0..2N-1 of last legal sample.
REQ-010 pos_vld  output  1  one-cycle pulse per legal decoded sample.
REQ-011 dir  output  1  direction of last step: 1=up (+1), 0=down (-1).
REQ-012 locked  output  1  high while FSM in LOCKED.
REQ-013 illegal  output  1  one-cycle pulse: sample not a legal Johnson code.
REQ-014 seq_err  output  1  one-cycle pulse: legal sample not equal prev, prev+1 or prev-1 (mod 2N).
REQ-015 err_count  output  8  saturating count of illegal + seq_err events.

Function
REQ-016 Code convention: state k (0..N) = k LSB ones; state k (N+1..2N-1) = k-N LSB zeros, remaining bits ones; WIDTH=8: 0x00=0, 0x01=1, 0xFF=8, 0xFE=9, 0x80=15.
REQ-017 Legality: code legal iff count of adjacent-bit differences (bit i vs i+1, i=0..N-2) <= 1.
REQ-018 Decode: all-zero -> 0; bit0=1 -> popcount; else -> 2N - popcount.
REQ-019 Pipeline: stage 1 registers code_in/code_vld; stage 2 decodes, checks, registers outputs; latency 2 clocks from code_vld edge to pos_vld/illegal/seq_err.
REQ-020 Accepts one sample per cycle back-to-back; no backpressure.
REQ-021 Step arithmetic modulo 2N: 2N-1 -> 0 is +1, 0 -> 2N-1 is -1.
REQ-022 FSM states HUNT, ACQUIRE, LOCKED; reset state HUNT.
REQ-023 HUNT: legal sample -> store pos as reference, step counter=0, go ACQUIRE; no seq_err in HUNT.
REQ-024 ACQUIRE: ±1 step -> counter+1, update dir; counter reaches LOCK_STEPS -> LOCKED same edge; non-adjacent legal sample -> seq_err, counter=0, stay ACQUIRE with new reference.
REQ-025 LOCKED: ±1 step -> update dir, stay; non-adjacent legal sample -> seq_err, go ACQUIRE with new reference.
REQ-026 Hold (sample == reference): pos_vld pulses, counter/dir/state unchanged, no error.
REQ-027 Direction reversal (+1 then -1) is a legal step; dir follows it, no error.
REQ-028 Illegal sample in any state: illegal pulse, no pos_vld, pos held, go HUNT.
REQ-029 err_count: +1 per illegal or seq_err event, saturates at 255.
REQ-030 clr_err and error same cycle: err_count = 1; clr_err alone: 0.
REQ-031 code_vld low: no pulses, state and outputs held.

Reset
REQ-032 rst high: state HUNT, pos=0, pos_vld=0, dir=0, locked=0, illegal=0, seq_err=0, err_count=0, step counter=0, stage-1 valid=0.
REQ-033 Reset mid-stream discards in-flight samples; no pulse emitted for samples present at reset.
REQ-034 First sample after reset release produces output 2 clocks later, as REQ-019.

Structure
REQ-035 Package johnson_pkg holds FSM state enum (HUNT, ACQUIRE, LOCKED), err counter max constant (255), lock counter width.
REQ-036 Sub-module johnson_decode: combinational code -> {legal, pos}, parameterized by WIDTH, reused by bench model.

Verification
REQ-037 Reset, then WIDTH=8 codes 0x00,0x01,0x03,0x07,0x0F -> pos 0..4, locked high 2 clocks after 5th sample, err_count=0.
REQ-038 Locked, codes 0xC0,0x80,0x00,0x01 -> pos 14,15,0,1, dir=1, no errors (wrap-around).
REQ-039 Locked at pos 4, code 0x3F (pos 6) -> seq_err pulse, err_count=1, locked low, state ACQUIRE.
REQ-040 Code 0x05 in LOCKED -> illegal pulse, no pos_vld, state HUNT, err_count+1.
REQ-041 Force 256 illegal codes -> err_count 255; then clr_err with illegal same cycle -> 1.
REQ-042 rst asserted one cycle after code_vld -> no pos_vld/illegal pulses, all outputs 0.
